// File: rtl/ex_mem_if.sv
// Execute-to-memory pipeline bus: execute-stage results in, registered memory-stage
// results and the multi-cycle accumulator feedback out.
interface ex_mem_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
);
  logic [REG_AW-1:0]   ex_wd;
  logic                ex_wreg;
  logic [DATA_W-1:0]   ex_wdata;
  logic                ex_whilo;
  logic [DATA_W-1:0]   ex_hi;
  logic [DATA_W-1:0]   ex_lo;
  logic [2*DATA_W-1:0] hilo_i;
  logic [1:0]          cnt_i;

  logic [REG_AW-1:0]   mem_wd;
  logic                mem_wreg;
  logic [DATA_W-1:0]   mem_wdata;
  logic                mem_whilo;
  logic [DATA_W-1:0]   mem_hi;
  logic [DATA_W-1:0]   mem_lo;
  logic [2*DATA_W-1:0] hilo_o;
  logic [1:0]          cnt_o;

  // Execute stage side: drives results, consumes the held accumulator.
  modport master (
    output ex_wd, ex_wreg, ex_wdata, ex_whilo, ex_hi, ex_lo, hilo_i, cnt_i,
    input  mem_wd, mem_wreg, mem_wdata, mem_whilo, mem_hi, mem_lo, hilo_o, cnt_o
  );

  // Pipeline register side.
  modport slave (
    input  ex_wd, ex_wreg, ex_wdata, ex_whilo, ex_hi, ex_lo, hilo_i, cnt_i,
    output mem_wd, mem_wreg, mem_wdata, mem_whilo, mem_hi, mem_lo, hilo_o, cnt_o
  );
endinterface

// File: rtl/ex_mem.sv
// EX/MEM pipeline register with a held partial-product accumulator and step counter
// so multi-cycle madd/msub can iterate while the execute stage is stalled.
module ex_mem #(
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 5,
  parameter int STALL_W = 6,
  parameter int EX_IDX  = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  ex_mem_if.slave            bus
);

  logic ex_stall;
  logic mem_stall;
  logic unused_stall;

  assign ex_stall     = stall[EX_IDX];
  assign mem_stall    = stall[EX_IDX+1];
  // Only the execute and memory bits matter; the rest are deliberately ignored.
  assign unused_stall = ^stall;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values and simulation ordering cannot change the result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.mem_wd    <= '0;
      bus.mem_wreg  <= 1'b0;
      bus.mem_wdata <= '0;
      bus.mem_whilo <= 1'b0;
      bus.mem_hi    <= '0;
      bus.mem_lo    <= '0;
      bus.hilo_o    <= '0;
      bus.cnt_o     <= '0;
    end else if (flush) begin
      // Flush also drops the accumulator, aborting any in-flight madd/msub.
      bus.mem_wd    <= '0;
      bus.mem_wreg  <= 1'b0;
      bus.mem_wdata <= '0;
      bus.mem_whilo <= 1'b0;
      bus.mem_hi    <= '0;
      bus.mem_lo    <= '0;
      bus.hilo_o    <= '0;
      bus.cnt_o     <= '0;
    end else if (!ex_stall) begin
      bus.mem_wd    <= bus.ex_wd;
      bus.mem_wreg  <= bus.ex_wreg;
      bus.mem_wdata <= bus.ex_wdata;
      bus.mem_whilo <= bus.ex_whilo;
      bus.mem_hi    <= bus.ex_hi;
      bus.mem_lo    <= bus.ex_lo;
      bus.hilo_o    <= '0;
      bus.cnt_o     <= '0;
    end else if (!mem_stall) begin
      // Execute is stalled but memory moves on: insert a NOP and capture the
      // iteration state execute needs on its next attempt.
      bus.mem_wd    <= '0;
      bus.mem_wreg  <= 1'b0;
      bus.mem_wdata <= '0;
      bus.mem_whilo <= 1'b0;
      bus.mem_hi    <= '0;
      bus.mem_lo    <= '0;
      bus.hilo_o    <= bus.hilo_i;
      bus.cnt_o     <= bus.cnt_i;
    end
    // Both stalled: every output holds.
  end

endmodule

// File: tb/tb_ex_mem.sv
// Scoreboard bench for ex_mem: directed scenarios followed by random traffic,
// each cycle's expected outputs queued by the driver and compared by a monitor.
module tb_ex_mem;

  localparam int DATA_W  = 32;
  localparam int REG_AW  = 5;
  localparam int STALL_W = 6;
  localparam int EX_IDX  = 3;

  typedef struct packed {
    logic [REG_AW-1:0]   wd;
    logic                wreg;
    logic [DATA_W-1:0]   wdata;
    logic                whilo;
    logic [DATA_W-1:0]   hi;
    logic [DATA_W-1:0]   lo;
    logic [2*DATA_W-1:0] hilo;
    logic [1:0]          cnt;
  } out_t;

  typedef struct {
    logic                rst;
    logic                flush;
    logic [STALL_W-1:0]  stall;
    logic [REG_AW-1:0]   wd;
    logic                wreg;
    logic [DATA_W-1:0]   wdata;
    logic                whilo;
    logic [DATA_W-1:0]   hi;
    logic [DATA_W-1:0]   lo;
    logic [2*DATA_W-1:0] hilo_i;
    logic [1:0]          cnt_i;
  } stim_t;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               flush = 1'b0;
  logic [STALL_W-1:0] stall = '0;

  ex_mem_if #(.DATA_W(DATA_W), .REG_AW(REG_AW)) bus ();

  ex_mem #(
    .DATA_W (DATA_W),
    .REG_AW (REG_AW),
    .STALL_W(STALL_W),
    .EX_IDX (EX_IDX)
  ) u_dut (
    .clk  (clk),
    .rst  (rst),
    .stall(stall),
    .flush(flush),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  int   errors = 0;
  int   checks = 0;
  out_t model  = '0;
  out_t sb[$];
  stim_t d;

  function automatic out_t actual();
    actual = '{bus.mem_wd, bus.mem_wreg, bus.mem_wdata, bus.mem_whilo,
               bus.mem_hi, bus.mem_lo, bus.hilo_o, bus.cnt_o};
  endfunction

  task automatic check(input string name, input out_t act, input out_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got wd=%0d wreg=%0b wdata=%h whilo=%0b hi=%h lo=%h hilo=%h cnt=%0d expected wd=%0d wreg=%0b wdata=%h whilo=%0b hi=%h lo=%h hilo=%h cnt=%0d",
               name, $time, act.wd, act.wreg, act.wdata, act.whilo, act.hi, act.lo, act.hilo, act.cnt,
               exp.wd, exp.wreg, exp.wdata, exp.whilo, exp.hi, exp.lo, exp.hilo, exp.cnt);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference behaviour: what the memory stage should see after one edge.
  function automatic out_t predict(input out_t cur, input stim_t s);
    out_t nxt;
    if (s.rst || s.flush) begin
      nxt = '0;
    end else if (!s.stall[EX_IDX]) begin
      nxt = '{s.wd, s.wreg, s.wdata, s.whilo, s.hi, s.lo, 64'd0, 2'd0};
    end else if (!s.stall[EX_IDX+1]) begin
      nxt = '{default: '0};
      nxt.hilo = s.hilo_i;
      nxt.cnt  = s.cnt_i;
    end else begin
      nxt = cur;
    end
    return nxt;
  endfunction

  // Apply d at the falling edge and queue the state expected after the next rise.
  task automatic step();
    @(negedge clk);
    rst          = d.rst;
    flush        = d.flush;
    stall        = d.stall;
    bus.ex_wd    = d.wd;
    bus.ex_wreg  = d.wreg;
    bus.ex_wdata = d.wdata;
    bus.ex_whilo = d.whilo;
    bus.ex_hi    = d.hi;
    bus.ex_lo    = d.lo;
    bus.hilo_i   = d.hilo_i;
    bus.cnt_i    = d.cnt_i;
    model = predict(model, d);
    sb.push_back(model);
  endtask

  function automatic stim_t idle();
    idle = '{rst: 1'b0, flush: 1'b0, stall: '0, wd: '0, wreg: 1'b0, wdata: '0,
             whilo: 1'b0, hi: '0, lo: '0, hilo_i: '0, cnt_i: '0};
  endfunction

  // Monitor: the register presents fresh outputs after every rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) check("cycle", actual(), sb.pop_front());
    end
  end

  initial begin
    out_t zero = '0;
    d = idle();
    bus.ex_wd = '0; bus.ex_wreg = 1'b0; bus.ex_wdata = '0; bus.ex_whilo = 1'b0;
    bus.ex_hi = '0; bus.ex_lo = '0; bus.hilo_i = '0; bus.cnt_i = '0;

    // Power-on reset, asserted between edges.
    #2 rst = 1'b1;
    #1 check("reset_async", actual(), zero);
    d.rst = 1'b1;
    step();
    d.rst = 1'b0;
    step();

    // Advance.
    d = idle(); d.wd = 5; d.wreg = 1'b1; d.wdata = 32'hDEADBEEF;
    step();

    // Bubble: writes suppressed, iteration state captured.
    d = idle(); d.stall = 6'b001111; d.wreg = 1'b1; d.whilo = 1'b1;
    d.wdata = 32'h1111_2222; d.hilo_i = 64'h12345678_9ABCDEF0; d.cnt_i = 2'b01;
    step();

    // Hold: preload mem_wdata=0x55, then freeze three edges.
    d = idle(); d.wdata = 32'h55; d.wreg = 1'b1; d.wd = 7;
    step();
    d = idle(); d.stall = 6'b011111; d.wdata = 32'hAA; d.hilo_i = 64'hFFFF; d.cnt_i = 2'b11;
    repeat (3) step();

    // Hold with a non-zero accumulator captured first.
    d = idle(); d.stall = 6'b001111; d.hilo_i = 64'hCAFE; d.cnt_i = 2'b10;
    step();
    d = idle(); d.stall = 6'b111000 | 6'b011000; d.hilo_i = 64'h1; d.cnt_i = 2'b01;
    repeat (2) step();

    // Flush over stall.
    d = idle(); d.stall = 6'b001111; d.cnt_i = 2'b01; d.hilo_i = 64'h77;
    step();
    d = idle(); d.flush = 1'b1; d.stall = 6'b001111; d.cnt_i = 2'b10; d.hilo_i = 64'h99;
    step();

    // madd: product step under stall, then accumulate and advance.
    d = idle(); d.stall = 6'b001111; d.cnt_i = 2'b01; d.hilo_i = 64'd6; d.whilo = 1'b1;
    step();
    d = idle(); d.whilo = 1'b1; d.hi = 0; d.lo = 6 + 10; d.cnt_i = 2'b10; d.hilo_i = 64'd16;
    step();

    // Reset mid-operation with cnt_o=01 and a held partial product.
    d = idle(); d.stall = 6'b001111; d.cnt_i = 2'b01; d.hilo_i = 64'h0000_0001_0000_0002;
    step();
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check("reset_mid_op", actual(), zero);
    model = '0;
    d = idle(); d.rst = 1'b1; d.stall = 6'b001111; d.cnt_i = 2'b11; d.hilo_i = 64'h5;
    step();
    d.rst = 1'b0;
    step();

    // Random traffic; other stall bits randomised to show they are ignored.
    for (int i = 0; i < 300; i++) begin
      d.rst    = ($urandom_range(63) == 0);
      d.flush  = ($urandom_range(15) == 0);
      d.stall  = STALL_W'($urandom);
      d.wd     = REG_AW'($urandom);
      d.wreg   = 1'($urandom);
      d.wdata  = $urandom;
      d.whilo  = 1'($urandom);
      d.hi     = $urandom;
      d.lo     = $urandom;
      d.hilo_i = {$urandom, $urandom};
      d.cnt_i  = 2'($urandom);
      step();
    end

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 5 && sb.size() > 0; i++) @(posedge clk);
    #2;
    check_int("scoreboard_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ex_mem.md
Name: ex_mem

Overview:
- Pipeline register between the execute stage and the memory-access stage of the 5-stage MIPS core.
- Captures the execute stage's register-file write, HI/LO write and result data each cycle, under control of the global stall vector and the exception flush.
- Also holds a 64-bit partial-product accumulator and a 2-bit step counter, which it returns to the execute stage so multi-cycle madd/maddu/msub/msubu can iterate while execute is stalled.

Parameters:
- DATA_W, 32, width of data, HI and LO words.
- REG_AW, 5, width of a general-register address.
- STALL_W, 6, width of the stall vector (pc, if, id, ex, mem, wb).
- EX_IDX, 3, stall-vector bit for the execute stage; bit EX_IDX+1 is the memory stage.

Ports:
- clk  in  1  pipeline clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- stall  in  STALL_W  per-stage stall request from the control unit.
- flush  in  1  exception flush; synchronous; clears the register.
- ex_wd  in  REG_AW  destination register from execute.
- ex_wreg  in  1  register-file write enable from execute.
- ex_wdata  in  DATA_W  result from execute.
- ex_whilo  in  1  HI/LO write enable from execute.
- ex_hi  in  DATA_W  HI value from execute.
- ex_lo  in  DATA_W  LO value from execute.
- hilo_i  in  2*DATA_W  partial product produced by execute this cycle.
- cnt_i  in  2  multi-cycle step count produced by execute.
- mem_wd  out  REG_AW  registered ex_wd.
- mem_wreg  out  1  registered ex_wreg.
- mem_wdata  out  DATA_W  registered ex_wdata.
- mem_whilo  out  1  registered ex_whilo.
- mem_hi  out  DATA_W  registered ex_hi.
- mem_lo  out  DATA_W  registered ex_lo.
- hilo_o  out  2*DATA_W  held partial product, fed back to execute.
- cnt_o  out  2  held step count, fed back to execute.

Behaviour:
- Reset: while rst=1, all outputs are 0 immediately (asynchronous assertion). Release takes effect at the next rising clk edge.
- All non-reset updates happen on the rising clk edge. Priority order: rst > flush > stall decode.
- Flush: when flush=1, all outputs are cleared to 0, including hilo_o and cnt_o. This aborts any in-flight madd/msub. Flush overrides stall.
- Advance (stall[EX_IDX]=0):
  - mem_* <= ex_*, giving one-cycle latency.
  - hilo_o <= 0 and cnt_o <= 0, so the accumulator is released.
- Bubble (stall[EX_IDX]=1, stall[EX_IDX+1]=0):
  - mem_wd, mem_wreg, mem_wdata, mem_whilo, mem_hi and mem_lo are driven to 0. This is a NOP; no register-file or HI/LO write leaks into memory.
  - hilo_o <= hilo_i and cnt_o <= cnt_i, so execute's iteration state is captured.
- Hold (stall[EX_IDX]=1, stall[EX_IDX+1]=1): every output keeps its current value.
- Bits of stall other than EX_IDX and EX_IDX+1 are ignored.
- Multi-cycle sequence (madd): execute asserts a stall and presents cnt_i=01 with the product in hilo_i. Next cycle it reads hilo_o and cnt_o=01, presents the accumulated sum and cnt_i=10, and drops the stall. The following edge advances the result and clears hilo_o and cnt_o.
- No combinational path from any input to any output.

Test Plan:
- Reset mid-operation: hold cnt_o=01 and hilo_o=0x0000_0001_0000_0002, assert rst between edges -> all outputs 0 immediately, before the next edge.
- Advance: stall=000000, ex_wd=5, ex_wreg=1, ex_wdata=0xDEADBEEF -> after one edge mem_wd=5, mem_wreg=1, mem_wdata=0xDEADBEEF, hilo_o=0, cnt_o=0.
- Bubble: stall=001111, ex_wreg=1, ex_whilo=1, hilo_i=0x12345678_9ABCDEF0, cnt_i=01 -> after the edge mem_wreg=0, mem_whilo=0, mem_wdata=0, hilo_o=0x12345678_9ABCDEF0, cnt_o=01.
- Hold: preload mem_wdata=0x55, then stall=011111 with ex_wdata=0xAA for 3 edges -> mem_wdata stays 0x55 and hilo_o/cnt_o are unchanged.
- Flush over stall: preload cnt_o=01, then flush=1 with stall=001111 -> after the edge all outputs 0.
- madd sequence: cycle 1 stall=001111, cnt_i=01, hilo_i=6. Cycle 2 stall=0, ex_whilo=1, ex_hi=0, ex_lo=6+10 -> mem_whilo=0 after edge 1, mem_lo=16 after edge 2, cnt_o back to 0.
